// File: rtl/fb_ex_muldiv_if.sv
// EX-stage M-extension bundle: held ID/EX operands and controls in, result strobe out.
interface fb_ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            ex_muldiv_valid;
  logic [2:0]      ex_muldiv_op;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [4:0]      ex_register_rd;
  logic            flush;
  logic            muldiv_stall;
  logic            muldiv_done;
  logic [XLEN-1:0] muldiv_result;
  logic [4:0]      muldiv_rd;

  // Pipeline side: drives the operation, observes stall and result.
  modport master (
    output ex_muldiv_valid, ex_muldiv_op, ex_rs1_data, ex_rs2_data, ex_register_rd, flush,
    input  muldiv_stall, muldiv_done, muldiv_result, muldiv_rd
  );

  // Multiply/divide unit side.
  modport slave (
    input  ex_muldiv_valid, ex_muldiv_op, ex_rs1_data, ex_rs2_data, ex_register_rd, flush,
    output muldiv_stall, muldiv_done, muldiv_result, muldiv_rd
  );
endinterface

// File: rtl/fb_ex_muldiv.sv
// Iterative RV32M multiply/divide unit. One bit per cycle: shift-add multiply
// (LSB first) and restoring divide (MSB first) share one hi/lo register pair.
// Divide-by-zero and signed overflow skip iteration and finish in two cycles.
module fb_ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  fb_ex_muldiv_if.slave bus
);
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   opnd_q;   // multiplicand for MUL*, divisor for DIV*/REM*
  logic [XLEN-1:0]   hi_q;     // product high / partial remainder
  logic [XLEN-1:0]   lo_q;     // multiplier -> product low / dividend -> quotient
  logic              neg_q;    // negate the selected result at the end
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   result_q;

  logic              start;
  logic              signed_a, signed_b, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag, special_result;
  logic              special;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [XLEN-1:0]   hi_n, lo_n, quot_c, rem_c, result_c;
  logic [2*XLEN-1:0] prod_c;

  assign start             = bus.ex_muldiv_valid & ~bus.flush & (state == IDLE);
  assign bus.muldiv_stall  = start | (state == CALC);
  assign bus.muldiv_done   = (state == DONE) & ~bus.flush;
  assign bus.muldiv_result = result_q;
  assign bus.muldiv_rd     = rd_q;

  // Operand decode at issue: signedness, magnitudes and the special divide cases.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    signed_a       = 1'b0;
    signed_b       = 1'b0;
    special        = 1'b0;
    special_result = '0;
    case (bus.ex_muldiv_op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin signed_a = 1'b1; signed_b = 1'b1; end
      OP_MULHSU:                       signed_a = 1'b1;
      default:                         ;
    endcase
    a_neg = signed_a & bus.ex_rs1_data[XLEN-1];
    b_neg = signed_b & bus.ex_rs2_data[XLEN-1];
    a_mag = a_neg ? -bus.ex_rs1_data : bus.ex_rs1_data;
    b_mag = b_neg ? -bus.ex_rs2_data : bus.ex_rs2_data;
    if (bus.ex_muldiv_op[2]) begin
      if (bus.ex_rs2_data == '0) begin
        special        = 1'b1;
        special_result = bus.ex_muldiv_op[1] ? bus.ex_rs1_data : '1;
      end else if ((bus.ex_muldiv_op == OP_DIV || bus.ex_muldiv_op == OP_REM) &&
                   bus.ex_rs1_data == {1'b1, {(XLEN-1){1'b0}}} && bus.ex_rs2_data == '1) begin
        special        = 1'b1;
        special_result = bus.ex_muldiv_op[1] ? '0 : bus.ex_rs1_data;
      end
    end
  end

  // One iteration step plus sign correction and result selection for the last step.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (op_q[2]) begin
      hi_n = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod_c = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
    quot_c = neg_q ? -lo_n : lo_n;
    rem_c  = neg_q ? -hi_n : hi_n;
    case (op_q)
      OP_MUL:                       result_c = prod_c[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result_c = prod_c[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result_c = quot_c;
      default:                      result_c = rem_c;
    endcase
  end

  // Control FSM and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
      cnt_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q   <= bus.ex_muldiv_op;
          rd_q   <= bus.ex_register_rd;
          cnt_q  <= '0;
          hi_q   <= '0;
          opnd_q <= bus.ex_muldiv_op[2] ? b_mag : a_mag;
          lo_q   <= bus.ex_muldiv_op[2] ? a_mag : b_mag;
          // Remainder follows the dividend's sign; product and quotient the XOR.
          neg_q  <= bus.ex_muldiv_op[1] & bus.ex_muldiv_op[2] ? a_neg : (a_neg ^ b_neg);
          if (special) begin
            result_q <= special_result;
            state    <= DONE;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          hi_q  <= hi_n;
          lo_q  <= lo_n;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) begin
            result_q <= result_c;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
